video_timing_gen: RTL
=====================

# video_timing_gen

Parametrised raster timing generator: the next generation of the fixed 341×262 NES-style timer. It divides the system clock into a dot clock and runs horizontal and vertical counters over configurable active/front/sync/back intervals. It drives sync, blanking, frame/line strobes, odd-frame tracking and a programmable line-match strobe. It sits between the system clock domain and the PPU renderer and video output encoder.

## Interface
- P_width, 16, width of the dot and line counters
- P_div, 4, system clocks per dot; even, ≥2
- P_active_h, 256, active dots per line
- P_front_h, 18, horizontal front porch (dots)
- P_sync_h, 25, horizontal sync width (dots)
- P_back_h, 42, horizontal back porch (dots)
- P_active_v, 240, active lines per frame
- P_front_v, 5, vertical front porch (lines)
- P_sync_v, 3, vertical sync width (lines)
- P_back_v, 14, vertical back porch (lines)
- P_h_offset, 1, first active dot index
- P_hsync_pol, 0, 0 means hsync is active-low, 1 means active-high
- P_vsync_pol, 0, same convention as P_hsync_pol, for vsync
- P_irq_dot, 0, dot index at which O_line_irq fires

Ports:
- I_clock  in  1  system clock
- I_reset  in  1  synchronous, active-high reset
- I_match_line  in  P_width  line index for O_line_irq; sampled every cycle
- I_render_en  in  1  rendering enabled; qualifies the odd-frame dot skip
- O_clock  out  1  dot clock, 50% duty
- O_rise  out  1  one-cycle dot enable
- O_hcount  out  P_width  dot index, 0..TH-1
- O_vcount  out  P_width  line index, 0..TV-1
- O_hsync, O_vsync  out  1  sync outputs, polarity set by parameter
- O_not_hblank, O_not_vblank, O_not_blank  out  1  active-region flags
- O_line_start, O_frame_start, O_line_irq  out  1  one-cycle strobes, each coincident with O_rise
- O_odd_frame  out  1  frame parity

## Operation
- TH = P_active_h+P_front_h+P_sync_h+P_back_h (default 341). TV is the vertical equivalent (default 262).
- Divider d runs 0..P_div-1 and wraps.
  - O_clock = (d ≥ P_div/2).
  - O_rise = (d == P_div/2).
- On each O_rise cycle:
  - hcount advances; at TH-1 it wraps to 0.
  - On the wrap, vcount advances; at TV-1 it wraps to 0.
  - On the vcount wrap, odd_frame toggles.
- O_not_hblank = hcount ∈ [P_h_offset, P_h_offset+P_active_h).
- O_not_vblank = vcount ∈ [0, P_active_v).
- O_not_blank = AND of O_not_hblank and O_not_vblank.
- Sync windows:
  - Hsync window is hcount ∈ [P_h_offset+P_active_h+P_front_h, +P_sync_h).
  - Vsync window is vcount ∈ [P_active_v+P_front_v+1, +P_sync_v).
  - Each output is asserted inside its window at the polarity set by its parameter.
- Strobes, each requiring O_rise:
  - O_line_start when hcount==0.
  - O_frame_start when hcount==0 and vcount==0.
  - O_line_irq when hcount==P_irq_dot and vcount==I_match_line.
- I_match_line ≥ TV never fires the strobe.
- All counter arithmetic is unsigned P_width. Elaboration fails (assert) if TH-1 or TV-1 exceeds 2^P_width-1, or if P_div is odd or <2.

## Timing
- Reset values: d=0, hcount=0, vcount=0, odd_frame=0, O_clock=0, O_rise=0.
  - Sync outputs are at their inactive level.
  - O_not_hblank=0 (when P_h_offset>0).
  - O_not_vblank=1.
  - All strobes are 0.
- First O_rise occurs P_div/2 cycles after reset deasserts. That cycle has hcount=0, vcount=0 and O_frame_start=1.
- Counters, d and odd_frame are registered. All flags and strobes decode combinationally from the registered state, with zero latency relative to O_hcount/O_vcount.
- Dot period is P_div cycles. One frame is TH·TV·P_div cycles, minus P_div on skipped frames.
- Reset mid-frame: on the next edge all state returns to reset values and no strobe is emitted. Reset has priority over all other updates.
- Simultaneous h-wrap, v-wrap and parity toggle all take effect on the same edge.

## Configuration
- VIDEO_TIMING_ODD_SKIP_EN defined:
  - Condition: O_odd_frame=1, I_render_en=1, vcount==TV-1 and hcount==TH-2, on an O_rise cycle.
  - Response: hcount wraps to 0, vcount wraps to 0 and parity toggles. Dot TH-1 of that line is skipped.
  - I_render_en is sampled on that O_rise cycle only.
- Undefined: I_render_en is ignored and every frame is TH·TV dots.

## Structure
- Package video_timing_pkg holds:
  - The NES default constants (the P_* defaults above).
  - A function computing totals from the four interval values.
  - Shared by the PPU and the output encoder.
- Sub-module dot_divider (parameter P_div) produces O_clock and O_rise. Counters, decode and skip logic stay in video_timing_gen.

## Test plan
- Reset released, default parameters -> first O_rise at cycle 2 with O_frame_start=1. Next O_frame_start 341·262·4 = 357368 cycles later.
- Count O_rise cycles between O_line_start pulses -> 341. O_not_hblank high for exactly hcount 1..256.
- O_hsync sampled across a line -> low for hcount 275..299 (25 dots). O_vsync low for vcount 246..248.
- I_match_line=100, P_irq_dot=0 -> exactly one O_line_irq per frame, at vcount=100, hcount=0. With I_match_line=300 -> none.
- VIDEO_TIMING_ODD_SKIP_EN defined, I_render_en=1 -> alternate frames are 89342 and 89341 dots. With I_render_en=0 -> all frames 89342.
- I_reset pulsed at vcount=120 -> next edge all counts 0, odd_frame=0, no strobes. Restart timing identical to the first scenario.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared raster timing constants and helpers for the video timing generator,
// the PPU renderer and the video output encoder. Defaults reproduce the
// NES 341x262 dot/line raster.
package video_timing_pkg;

    localparam int unsigned NES_WIDTH     = 16;
    localparam int unsigned NES_DIV       = 4;
    localparam int unsigned NES_ACTIVE_H  = 256;
    localparam int unsigned NES_FRONT_H   = 18;
    localparam int unsigned NES_SYNC_H    = 25;
    localparam int unsigned NES_BACK_H    = 42;
    localparam int unsigned NES_ACTIVE_V  = 240;
    localparam int unsigned NES_FRONT_V   = 5;
    localparam int unsigned NES_SYNC_V    = 3;
    localparam int unsigned NES_BACK_V    = 14;
    localparam int unsigned NES_H_OFFSET  = 1;
    localparam bit          NES_HSYNC_POL = 1'b0;
    localparam bit          NES_VSYNC_POL = 1'b0;
    localparam int unsigned NES_IRQ_DOT   = 0;

    // Total period (dots per line or lines per frame) from its four intervals.
    function automatic int unsigned timing_total(
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync,
        input int unsigned back
    );
        return active + front + sync + back;
    endfunction

    localparam int unsigned NES_TH = timing_total(NES_ACTIVE_H, NES_FRONT_H, NES_SYNC_H, NES_BACK_H);
    localparam int unsigned NES_TV = timing_total(NES_ACTIVE_V, NES_FRONT_V, NES_SYNC_V, NES_BACK_V);

endpackage

// File: rtl/video_timing_gen_if.sv
// Signal bundle between the raster timing generator (master) and its
// consumers (slave): line-match/render-enable controls in, timing out.
interface video_timing_gen_if
    import video_timing_pkg::*;
#(
    parameter int unsigned P_width = NES_WIDTH
);
    logic [P_width-1:0] I_match_line;
    logic               I_render_en;
    logic               O_clock;
    logic               O_rise;
    logic [P_width-1:0] O_hcount;
    logic [P_width-1:0] O_vcount;
    logic               O_hsync;
    logic               O_vsync;
    logic               O_not_hblank;
    logic               O_not_vblank;
    logic               O_not_blank;
    logic               O_line_start;
    logic               O_frame_start;
    logic               O_line_irq;
    logic               O_odd_frame;

    modport master (
        input  I_match_line, I_render_en,
        output O_clock, O_rise, O_hcount, O_vcount, O_hsync, O_vsync,
               O_not_hblank, O_not_vblank, O_not_blank,
               O_line_start, O_frame_start, O_line_irq, O_odd_frame
    );

    modport slave (
        output I_match_line, I_render_en,
        input  O_clock, O_rise, O_hcount, O_vcount, O_hsync, O_vsync,
               O_not_hblank, O_not_vblank, O_not_blank,
               O_line_start, O_frame_start, O_line_irq, O_odd_frame
    );
endinterface

// File: rtl/video_timing_gen_dot_divider.sv
// Dot clock divider: a phase counter over P_div system clocks producing a
// 50% duty dot clock and a one-cycle enable on its rising phase.
module dot_divider #(
    parameter int unsigned P_div = 4
) (
    input  logic I_clock,
    input  logic I_reset,
    output logic O_clock,
    output logic O_rise
);
    localparam int unsigned   DW     = (P_div > 2) ? $clog2(P_div) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(P_div - 1);
    localparam logic [DW-1:0] D_HALF = DW'(P_div / 2);

    logic [DW-1:0] d_q;
    logic [DW-1:0] d_d;

    // Next phase: count up and wrap after the last system clock of a dot.
    always_comb begin
        d_d = d_q + DW'(1);
        if (d_q == D_LAST) begin
            d_d = '0;
        end
    end

    // Phase register.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    assign O_clock = (d_q >= D_HALF);
    assign O_rise  = (d_q == D_HALF);
endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator. Divides the system clock into a dot
// clock, runs dot/line counters and decodes sync, blanking and strobes
// combinationally from the registered counters.
// Optional feature: define VIDEO_TIMING_ODD_SKIP_EN to drop the last dot of
// the final line of odd frames while rendering is enabled.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned P_width     = NES_WIDTH,
    parameter int unsigned P_div       = NES_DIV,
    parameter int unsigned P_active_h  = NES_ACTIVE_H,
    parameter int unsigned P_front_h   = NES_FRONT_H,
    parameter int unsigned P_sync_h    = NES_SYNC_H,
    parameter int unsigned P_back_h    = NES_BACK_H,
    parameter int unsigned P_active_v  = NES_ACTIVE_V,
    parameter int unsigned P_front_v   = NES_FRONT_V,
    parameter int unsigned P_sync_v    = NES_SYNC_V,
    parameter int unsigned P_back_v    = NES_BACK_V,
    parameter int unsigned P_h_offset  = NES_H_OFFSET,
    parameter bit          P_hsync_pol = NES_HSYNC_POL,
    parameter bit          P_vsync_pol = NES_VSYNC_POL,
    parameter int unsigned P_irq_dot   = NES_IRQ_DOT
) (
    input  logic              I_clock,
    input  logic              I_reset,
    video_timing_gen_if.master vt
);
    localparam int unsigned TH = timing_total(P_active_h, P_front_h, P_sync_h, P_back_h);
    localparam int unsigned TV = timing_total(P_active_v, P_front_v, P_sync_v, P_back_v);

`ifdef VIDEO_TIMING_ODD_SKIP_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    // Configuration sanity: counters must hold TH-1/TV-1, divider must split evenly.
    if ((P_div % 2) != 0 || P_div < 2) begin : g_bad_div
        $error("video_timing_gen: P_div must be even and at least 2");
    end
    if ((longint'(TH) - 1) > ((longint'(1) << P_width) - 1)) begin : g_bad_th
        $error("video_timing_gen: TH-1 does not fit in P_width bits");
    end
    if ((longint'(TV) - 1) > ((longint'(1) << P_width) - 1)) begin : g_bad_tv
        $error("video_timing_gen: TV-1 does not fit in P_width bits");
    end

    // Decode bounds are one bit wider than the counters so a window ending
    // exactly at 2^P_width stays representable.
    localparam int unsigned    EW        = P_width + 1;
    localparam logic [P_width-1:0] H_LAST  = P_width'(TH - 1);
    localparam logic [P_width-1:0] H_SKIP  = P_width'(TH - 2);
    localparam logic [P_width-1:0] V_LAST  = P_width'(TV - 1);
    localparam logic [P_width-1:0] IRQ_DOT = P_width'(P_irq_dot);
    localparam logic [EW-1:0] H_ACT_LO = EW'(P_h_offset);
    localparam logic [EW-1:0] H_ACT_HI = EW'(P_h_offset + P_active_h);
    localparam logic [EW-1:0] HS_LO    = EW'(P_h_offset + P_active_h + P_front_h);
    localparam logic [EW-1:0] HS_HI    = EW'(P_h_offset + P_active_h + P_front_h + P_sync_h);
    localparam logic [EW-1:0] V_ACT_HI = EW'(P_active_v);
    localparam logic [EW-1:0] VS_LO    = EW'(P_active_v + P_front_v + 1);
    localparam logic [EW-1:0] VS_HI    = EW'(P_active_v + P_front_v + 1 + P_sync_v);

    logic               dot_clock;
    logic               dot_rise;
    logic [P_width-1:0] hcount_q, hcount_d;
    logic [P_width-1:0] vcount_q, vcount_d;
    logic               odd_frame_q, odd_frame_d;
    logic               skip_dot;

    logic               hs_win, vs_win;
    logic               not_hblank, not_vblank;
    logic               line_start, frame_start, line_irq;
    logic [EW-1:0]      h_ext, v_ext;

    dot_divider #(
        .P_div(P_div)
    ) u_dot_divider (
        .I_clock(I_clock),
        .I_reset(I_reset),
        .O_clock(dot_clock),
        .O_rise (dot_rise)
    );

    // Next counter state: advance on each dot, wrap lines/frames, toggle
    // parity on frame wrap; an odd rendering frame may end one dot early.
    always_comb begin
        hcount_d    = hcount_q;
        vcount_d    = vcount_q;
        odd_frame_d = odd_frame_q;
        skip_dot    = SKIP_EN && odd_frame_q && vt.I_render_en &&
                      (vcount_q == V_LAST) && (hcount_q == H_SKIP);
        if (dot_rise) begin
            if (skip_dot || hcount_q == H_LAST) begin
                hcount_d = '0;
                if (skip_dot || vcount_q == V_LAST) begin
                    vcount_d    = '0;
                    odd_frame_d = ~odd_frame_q;
                end else begin
                    vcount_d = vcount_q + P_width'(1);
                end
            end else begin
                hcount_d = hcount_q + P_width'(1);
            end
        end
    end

    // Counter and parity registers; reset overrides any pending update.
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            odd_frame_q <= 1'b0;
        end else begin
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            odd_frame_q <= odd_frame_d;
        end
    end

    // Zero-latency decode of windows and strobes from the registered counters.
    always_comb begin
        h_ext       = {1'b0, hcount_q};
        v_ext       = {1'b0, vcount_q};
        not_hblank  = (h_ext >= H_ACT_LO) && (h_ext < H_ACT_HI);
        not_vblank  = (v_ext < V_ACT_HI);
        hs_win      = (h_ext >= HS_LO) && (h_ext < HS_HI);
        vs_win      = (v_ext >= VS_LO) && (v_ext < VS_HI);
        line_start  = dot_rise && (hcount_q == '0);
        frame_start = line_start && (vcount_q == '0);
        line_irq    = dot_rise && (hcount_q == IRQ_DOT) && (vcount_q == vt.I_match_line);
    end

    assign vt.O_clock       = dot_clock;
    assign vt.O_rise        = dot_rise;
    assign vt.O_hcount      = hcount_q;
    assign vt.O_vcount      = vcount_q;
    assign vt.O_hsync       = P_hsync_pol ? hs_win : ~hs_win;
    assign vt.O_vsync       = P_vsync_pol ? vs_win : ~vs_win;
    assign vt.O_not_hblank  = not_hblank;
    assign vt.O_not_vblank  = not_vblank;
    assign vt.O_not_blank   = not_hblank && not_vblank;
    assign vt.O_line_start  = line_start;
    assign vt.O_frame_start = frame_start;
    assign vt.O_line_irq    = line_irq;
    assign vt.O_odd_frame   = odd_frame_q;
endmodule
